// File: rtl/piso_serializer_if.sv
// Handshake bundle for piso_serializer: parallel word in, symbol stream out.
// The slave modport is the serializer's view; master is the surrounding logic.
interface piso_serializer_if #(
  parameter int WIDTH    = 8,
  parameter int SYM_BITS = 1
);
  logic [WIDTH-1:0]    par_data;
  logic                par_valid;
  logic                par_ready;
  logic [SYM_BITS-1:0] ser_data;
  logic                ser_valid;
  logic                ser_last;
  logic                ser_ready;

  modport slave (
    input  par_data,
    input  par_valid,
    input  ser_ready,
    output par_ready,
    output ser_data,
    output ser_valid,
    output ser_last
  );

  modport master (
    output par_data,
    output par_valid,
    output ser_ready,
    input  par_ready,
    input  ser_data,
    input  ser_valid,
    input  ser_last
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out converter emitting WIDTH/SYM_BITS symbols per word.
// Define PISO_PARITY_EN to append an even-parity symbol after each word.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int SYM_BITS  = 1,
  parameter int MSB_FIRST = 1,
  parameter int HOLD      = 1
) (
  input  logic             clk_sig,
  input  logic             reset_sig,
  piso_serializer_if.slave bus
);

  localparam int NSYM = WIDTH / SYM_BITS;
`ifdef PISO_PARITY_EN
  localparam int NTOT = NSYM + 1;
`else
  localparam int NTOT = NSYM;
`endif
  localparam int SW = $clog2(((NSYM + 1) > 2) ? (NSYM + 1) : 2);
  localparam int HW = $clog2((HOLD > 2) ? HOLD : 2);

  localparam logic [SW-1:0] LAST_IDX = SW'(NTOT - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       sym_cnt_q, sym_cnt_d;
  logic [HW-1:0]       hold_cnt_q, hold_cnt_d;
  logic [WIDTH-1:0]    word_q, word_d;
  logic [SYM_BITS-1:0] ser_data_q, ser_data_d;
  logic                ser_valid_q, ser_valid_d;
  logic                ser_last_q, ser_last_d;

  logic consume;
  logic last_consume;
  logic par_ready;
  logic load;

  // Index NSYM is only reachable with parity enabled and selects the parity symbol.
  function automatic logic [SYM_BITS-1:0] pick_sym(input logic [WIDTH-1:0] word,
                                                   input logic [SW-1:0]    idx);
    logic [WIDTH-1:0] shifted;
    int unsigned      k;
    k = 32'(idx);
    if (MSB_FIRST != 0) begin
      shifted = word >> (WIDTH - (k + 1) * SYM_BITS);
    end else begin
      shifted = word >> (k * SYM_BITS);
    end
    pick_sym = shifted[SYM_BITS-1:0];
`ifdef PISO_PARITY_EN
    if (k == NSYM) begin
      pick_sym    = '0;
      pick_sym[0] = ^word;
    end
`endif
  endfunction

  always_comb begin
    consume      = ser_valid_q && (hold_cnt_q == HOLD_MAX) && bus.ser_ready;
    last_consume = consume && ser_last_q;
    par_ready    = !reset_sig && ((state_q == IDLE) || last_consume);
    load         = bus.par_valid && par_ready;
  end

  // A load can only coincide with idle or the final consumption, which gives the no-bubble hand-over.
  always_comb begin
    state_d     = state_q;
    sym_cnt_d   = sym_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    word_d      = word_q;
    ser_data_d  = ser_data_q;
    ser_valid_d = ser_valid_q;
    ser_last_d  = ser_last_q;

    if (load) begin
      state_d     = SHIFT;
      word_d      = bus.par_data;
      sym_cnt_d   = '0;
      hold_cnt_d  = '0;
      ser_data_d  = pick_sym(bus.par_data, '0);
      ser_valid_d = 1'b1;
      ser_last_d  = (NTOT == 1);
    end else if (last_consume) begin
      state_d     = IDLE;
      sym_cnt_d   = '0;
      hold_cnt_d  = '0;
      ser_data_d  = '0;
      ser_valid_d = 1'b0;
      ser_last_d  = 1'b0;
    end else if (consume) begin
      sym_cnt_d  = sym_cnt_q + 1'b1;
      hold_cnt_d = '0;
      ser_data_d = pick_sym(word_q, sym_cnt_d);
      ser_last_d = (sym_cnt_d == LAST_IDX);
    end else if (ser_valid_q && (hold_cnt_q != HOLD_MAX)) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_sig) begin
    if (reset_sig) begin
      state_q     <= IDLE;
      sym_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      word_q      <= '0;
      ser_data_q  <= '0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sym_cnt_q   <= sym_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      word_q      <= word_d;
      ser_data_q  <= ser_data_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
    end
  end

  assign bus.par_ready = par_ready;
  assign bus.ser_data  = ser_data_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.ser_last  = ser_last_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: two configurations (8/1/MSB/HOLD1 and 8/2/LSB/HOLD2)
// driven with the same inputs; table vectors, hand sequences and a queue model.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int NA = 9;
  localparam int NB = 5;
`else
  localparam int NA = 8;
  localparam int NB = 4;
`endif

  typedef struct {
    string      nm;
    bit         rst;
    bit         pv;
    logic [7:0] pd;
    bit         sr;
    int         sel;
    bit         ev;
    int         ed;
    bit         el;
    bit         epr;
    bit         strict;
  } vec_t;

  vec_t vecs[$];

  logic clk = 1'b0;
  logic rst;
  int   check_cnt = 0;
  int   pass_cnt  = 0;

  int a5[9];
  int c3[9];
  int b4[5];
  int b81[9];
  int b07[9];
  int mq[$];
  int held;

  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(8), .SYM_BITS(1)) if_a ();
  piso_serializer_if #(.WIDTH(8), .SYM_BITS(2)) if_b ();

  piso_serializer #(.WIDTH(8), .SYM_BITS(1), .MSB_FIRST(1), .HOLD(1)) dut_a (
    .clk_sig  (clk),
    .reset_sig(rst),
    .bus      (if_a)
  );

  piso_serializer #(.WIDTH(8), .SYM_BITS(2), .MSB_FIRST(0), .HOLD(2)) dut_b (
    .clk_sig  (clk),
    .reset_sig(rst),
    .bus      (if_b)
  );

  function automatic void addVec(string nm, bit r, bit pv, logic [7:0] pd, bit sr, int sel,
                                 bit ev, int ed, bit el, bit epr, bit strict);
    vec_t v;
    v.nm = nm; v.rst = r; v.pv = pv; v.pd = pd; v.sr = sr; v.sel = sel;
    v.ev = ev; v.ed = ed; v.el = el; v.epr = epr; v.strict = strict;
    vecs.push_back(v);
  endfunction

  function automatic void cmp(string nm, int act, int exp);
    check_cnt++;
    if (act == exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d expected %0d", nm, act, exp);
  endfunction

  // Inputs go to both DUTs; outputs are sampled on the falling edge.
  task automatic applyStimulus(input bit r, input bit pv, input logic [7:0] pd, input bit sr);
    rst            = r;
    if_a.par_valid = pv;
    if_a.par_data  = pd;
    if_a.ser_ready = sr;
    if_b.par_valid = pv;
    if_b.par_data  = pd;
    if_b.ser_ready = sr;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string nm, input int sel, input bit ev, input int ed,
                             input bit el, input bit epr, input bit strict);
    int av, ad, al, apr;
    if (sel == 0) begin
      av = int'(if_a.ser_valid); ad = int'(if_a.ser_data);
      al = int'(if_a.ser_last);  apr = int'(if_a.par_ready);
    end else begin
      av = int'(if_b.ser_valid); ad = int'(if_b.ser_data);
      al = int'(if_b.ser_last);  apr = int'(if_b.par_ready);
    end
    cmp({nm, ".ser_valid"}, av, int'(ev));
    cmp({nm, ".par_ready"}, apr, int'(epr));
    if (ev || strict) begin
      cmp({nm, ".ser_data"}, ad, ed);
      cmp({nm, ".ser_last"}, al, int'(el));
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    nextCycle();
  endtask

  // Plays one word on DUT A with ser_ready high, then checks the idle cycle after it.
  task automatic playWordA(input string nm, input logic [7:0] w, input int syms[9]);
    doReset();
    applyStimulus(1'b0, 1'b1, w, 1'b1);
    checkOutput({nm, ".load"}, 0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
    nextCycle();
    for (int c = 0; c < NA; c++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput($sformatf("%s.sym%0d", nm, c), 0, 1'b1, syms[c], c == NA - 1, c == NA - 1, 1'b0);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput({nm, ".idle"}, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    nextCycle();
  endtask

  // Reference model: a queue of pending symbols for the word on the wire plus a hold counter.
  task automatic randomPhase(input int sel, input int cycles);
    int         hold, sb, nsym, mask, sh;
    bit         msb, r, pv, sr, ev, epr;
    logic [7:0] pd;
    hold = (sel == 0) ? 1 : 2;
    sb   = (sel == 0) ? 1 : 2;
    msb  = (sel == 0);
    nsym = 8 / sb;
    mask = (1 << sb) - 1;
    mq.delete();
    held = 0;
    doReset();
    for (int c = 0; c < cycles; c++) begin
      r   = ($urandom_range(63) == 0);
      pv  = ($urandom_range(9) < 7);
      sr  = ($urandom_range(9) < 7);
      pd  = 8'($urandom);
      ev  = (mq.size() > 0);
      epr = !r && ((mq.size() == 0) || (mq.size() == 1 && held == hold - 1 && sr));
      applyStimulus(r, pv, pd, sr);
      checkOutput($sformatf("rand%0d[%0d]", sel, c), sel, ev, ev ? mq[0] : 0,
                  mq.size() == 1, epr, 1'b0);
      if (r) begin
        mq.delete();
        held = 0;
      end else begin
        if (ev) begin
          if (held == hold - 1) begin
            if (sr) begin
              void'(mq.pop_front());
              held = 0;
            end
          end else begin
            held++;
          end
        end
        if (pv && epr) begin
          for (int k = 0; k < nsym; k++) begin
            sh = msb ? (8 - (k + 1) * sb) : (k * sb);
            mq.push_back((int'(pd) >> sh) & mask);
          end
`ifdef PISO_PARITY_EN
          mq.push_back($countones(pd) % 2);
`endif
        end
      end
      nextCycle();
    end
  endtask

  initial begin
    int idx;
    bit sr;
    a5  = '{1, 0, 1, 0, 0, 1, 0, 1, 0};
    c3  = '{0, 0, 1, 1, 1, 1, 0, 0, 0};
    b4  = '{0, 1, 3, 2, 0};
    b81 = '{1, 0, 0, 0, 0, 0, 0, 1, 0};
    b07 = '{0, 0, 0, 0, 0, 1, 1, 1, 1};

    // Single word 0xA5 on DUT A
    addVec("t1.load", 0, 1, 8'hA5, 1, 0, 0, 0, 0, 1, 1);
    for (int c = 1; c <= NA; c++)
      addVec($sformatf("t1.c%0d", c), 0, 0, 8'h00, 1, 0, 1, a5[c-1], c == NA, c == NA, 0);
    addVec("t1.idle", 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 0);
    addVec("t1.rst", 1, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0);

    // Back-to-back 0xA5, 0x3C with par_valid held
    addVec("t2.load", 0, 1, 8'hA5, 1, 0, 0, 0, 0, 1, 1);
    for (int c = 1; c <= 2 * NA; c++)
      addVec($sformatf("t2.c%0d", c), 0, c <= NA, 8'h3C, 1, 0, 1,
             (c <= NA) ? a5[c-1] : c3[c-NA-1], c == NA || c == 2 * NA, c == NA || c == 2 * NA, 0);
    addVec("t2.idle", 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 0);
    addVec("t2.rst", 1, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0);

    // DUT B: 0xB4 as 2-bit LSB-first symbols held 2 cycles each
    addVec("t4.load", 0, 1, 8'hB4, 1, 1, 0, 0, 0, 1, 1);
    for (int c = 1; c <= 2 * NB; c++)
      addVec($sformatf("t4.c%0d", c), 0, 0, 8'h00, 1, 1, 1, b4[(c-1)/2],
             (c - 1) / 2 == NB - 1, ((c - 1) / 2 == NB - 1) && (c % 2 == 0), 0);
    addVec("t4.idle", 0, 0, 8'h00, 1, 1, 0, 0, 0, 1, 0);
    addVec("t4.rst", 1, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0);

    rst = 1'b1;
    if_a.par_valid = 1'b0; if_a.par_data = 8'h00; if_a.ser_ready = 1'b1;
    if_b.par_valid = 1'b0; if_b.par_data = 8'h00; if_b.ser_ready = 1'b1;
    nextCycle();
    doReset();

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].pv, vecs[i].pd, vecs[i].sr);
      checkOutput(vecs[i].nm, vecs[i].sel, vecs[i].ev, vecs[i].ed, vecs[i].el, vecs[i].epr,
                  vecs[i].strict);
      nextCycle();
    end

    // Stall: ser_ready low for 3 cycles while the third symbol of 0xA5 is shown
    doReset();
    applyStimulus(1'b0, 1'b1, 8'hA5, 1'b1);
    checkOutput("t3.load", 0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
    nextCycle();
    idx = 0;
    for (int c = 0; c < NA + 3; c++) begin
      sr = !(c >= 2 && c <= 4);
      applyStimulus(1'b0, 1'b0, 8'h00, sr);
      checkOutput($sformatf("t3.c%0d", c), 0, 1'b1, a5[idx], idx == NA - 1,
                  (idx == NA - 1) && sr, 1'b0);
      nextCycle();
      if (sr) idx++;
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("t3.idle", 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    nextCycle();

    // Reset while the 4th bit of 0xFF is out, then 0x81
    doReset();
    applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1);
    checkOutput("t5.load", 0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
    nextCycle();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput($sformatf("t5.ff%0d", c), 0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
      nextCycle();
    end
    applyStimulus(1'b1, 1'b1, 8'h00, 1'b1);
    checkOutput("t5.inrst", 0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 8'h81, 1'b1);
    checkOutput("t5.after", 0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
    nextCycle();
    for (int c = 0; c < NA; c++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput($sformatf("t5.sym%0d", c), 0, 1'b1, b81[c], c == NA - 1, c == NA - 1, 1'b0);
      nextCycle();
    end

    // 0x07: odd parity weight, parity symbol is 1 when enabled
    playWordA("t6", 8'h07, b07);

    randomPhase(0, 800);
    randomPhase(1, 800);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
